// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg -- shared definitions for the gshare branch predictor.
//   * default parameter widths (index, counter, global history)
//   * FSM state encodings (INIT sweep / RUN)
//   * pattern-table write operation codes
//   * counter initialisation value helper (weakly not-taken: 2^(CTR_W-1)-1)
// Optional build feature elsewhere in the slice: GSHARE_BP_STATS_EN.
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_IDX_W = 8;
  localparam int BP_CTR_W = 2;
  localparam int BP_GHR_W = 8;

  // Two-state controller: the table is swept to a known value before use.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Pattern-table write operations.
  localparam logic [1:0] PHT_OP_LOAD = 2'd0;
  localparam logic [1:0] PHT_OP_INC  = 2'd1;
  localparam logic [1:0] PHT_OP_DEC  = 2'd2;

  // Weakly-not-taken starting value for a counter of the given width.
  function automatic int bp_ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// -----------------------------------------------------------------------------
// bp_pht -- pattern history table of saturating counters.
// Ports:
//   clk      in           clock; writes on rising edge
//   rd_idx   in  IDX_W    asynchronous read address
//   rd_data  out CTR_W    counter at rd_idx (pre-write value in a same-cycle write)
//   wr_en    in  1        write enable
//   wr_idx   in  IDX_W    write address
//   wr_op    in  2        LOAD wr_data / saturating INC / saturating DEC
//   wr_data  in  CTR_W    value for LOAD
// The single write port performs the read-modify-write internally so that the
// external read port is dedicated to fetch-side prediction.
// The array itself carries no reset; the owner sweeps it after reset.
// -----------------------------------------------------------------------------
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int CTR_W = BP_CTR_W
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_op,
  input  logic [CTR_W-1:0] wr_data
);

  logic [CTR_W-1:0] mem [2**IDX_W];
  logic [CTR_W-1:0] wr_cur;
  logic [CTR_W-1:0] wr_nxt;

  assign rd_data = mem[rd_idx];
  assign wr_cur  = mem[wr_idx];

  // Next counter value for the addressed entry (saturating at both ends).
  always_comb begin
    wr_nxt = wr_cur;
    case (wr_op)
      PHT_OP_LOAD: wr_nxt = wr_data;
      PHT_OP_INC: begin
        if (wr_cur != {CTR_W{1'b1}}) begin
          wr_nxt = wr_cur + {{(CTR_W-1){1'b0}}, 1'b1};
        end else begin
          wr_nxt = wr_cur;
        end
      end
      PHT_OP_DEC: begin
        if (wr_cur != {CTR_W{1'b0}}) begin
          wr_nxt = wr_cur - {{(CTR_W-1){1'b0}}, 1'b1};
        end else begin
          wr_nxt = wr_cur;
        end
      end
      default: wr_nxt = wr_cur;
    endcase
  end

  // Counter array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// -----------------------------------------------------------------------------
// gshare_bp -- gshare conditional-branch direction predictor.
// Index = PC[IDX_W+1:2] XOR zero-extended global history.
// Ports:
//   clk, rst (async, active-low), rdy (global enable; all state holds when low)
//   in_fetcher_ce / in_fetcher_pc       fetch-side query
//   out_fetcher_jump_ce / out_fetcher_ghr  prediction and history snapshot (comb.)
//   in_rob_bp_ce / in_rob_pc / in_rob_ghr / in_rob_jump_ce / in_rob_mispredict
//                                        committed-branch training and recovery
//   out_busy                             table initialisation sweep in progress
//   out_stat_lookups / out_stat_mispredicts  only with GSHARE_BP_STATS_EN defined
// -----------------------------------------------------------------------------
module gshare_bp
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int CTR_W = BP_CTR_W,
  parameter int GHR_W = BP_GHR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_fetcher_ce,
  input  logic [31:0]      in_fetcher_pc,
  output logic             out_fetcher_jump_ce,
  output logic [GHR_W-1:0] out_fetcher_ghr,
  input  logic             in_rob_bp_ce,
  input  logic [31:0]      in_rob_pc,
  input  logic [GHR_W-1:0] in_rob_ghr,
  input  logic             in_rob_jump_ce,
  input  logic             in_rob_mispredict,
  output logic             out_busy
`ifdef GSHARE_BP_STATS_EN
  ,
  output logic [31:0]      out_stat_lookups,
  output logic [31:0]      out_stat_mispredicts
`endif
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(bp_ctr_init(CTR_W));

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_ptr;
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_next;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] rob_ghr_ext;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] rob_idx;
  logic [CTR_W-1:0] pht_rd_data;
  logic             pht_wr_en;
  logic [IDX_W-1:0] pht_wr_idx;
  logic [1:0]       pht_wr_op;
  logic             busy;
  logic             pred;
  logic             fetch_fire;
  logic             rob_fire;
  logic             misp_fire;
  logic             pc_unused;
  logic             pht_rd_unused;

  assign busy       = (state == ST_INIT);
  assign fetch_fire = rdy & ~busy & in_fetcher_ce;
  assign rob_fire   = rdy & ~busy & in_rob_bp_ce;
  assign misp_fire  = rob_fire & in_rob_mispredict;

  // Zero-extend both history values to index width (works for GHR_W == IDX_W).
  always_comb begin
    ghr_ext                  = {IDX_W{1'b0}};
    ghr_ext[GHR_W-1:0]       = ghr;
    rob_ghr_ext              = {IDX_W{1'b0}};
    rob_ghr_ext[GHR_W-1:0]   = in_rob_ghr;
  end

  assign fetch_idx = in_fetcher_pc[IDX_W+1:2] ^ ghr_ext;
  assign rob_idx   = in_rob_pc[IDX_W+1:2] ^ rob_ghr_ext;

  // Only the index bits of the PCs and the counter MSB are consumed.
  assign pc_unused     = ^{in_fetcher_pc, in_rob_pc};
  assign pht_rd_unused = ^pht_rd_data;

  assign pred                = busy ? 1'b0 : pht_rd_data[CTR_W-1];
  assign out_fetcher_jump_ce = pred;
  assign out_fetcher_ghr     = ghr;
  assign out_busy            = busy;

  // Write-port arbitration: the init sweep owns the port until RUN.
  always_comb begin
    pht_wr_en  = 1'b0;
    pht_wr_idx = rob_idx;
    pht_wr_op  = PHT_OP_LOAD;
    if (busy) begin
      pht_wr_en  = rdy;
      pht_wr_idx = sweep_ptr;
      pht_wr_op  = PHT_OP_LOAD;
    end else begin
      pht_wr_en  = rob_fire;
      pht_wr_idx = rob_idx;
      pht_wr_op  = in_rob_jump_ce ? PHT_OP_INC : PHT_OP_DEC;
    end
  end

  bp_pht #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk     (clk),
    .rd_idx  (fetch_idx),
    .rd_data (pht_rd_data),
    .wr_en   (pht_wr_en),
    .wr_idx  (pht_wr_idx),
    .wr_op   (pht_wr_op),
    .wr_data (CTR_INIT)
  );

  // Next history: a mispredict recovery wins over the speculative shift.
  always_comb begin
    ghr_next = ghr;
    if (misp_fire) begin
      ghr_next    = in_rob_ghr << 1;
      ghr_next[0] = in_rob_jump_ce;
    end else if (fetch_fire) begin
      ghr_next    = ghr << 1;
      ghr_next[0] = pred;
    end else begin
      ghr_next = ghr;
    end
  end

  // Init-sweep controller: one entry per enabled cycle, then RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep_ptr <= {IDX_W{1'b0}};
    end else if (rdy) begin
      case (state)
        ST_INIT: begin
          sweep_ptr <= sweep_ptr + {{(IDX_W-1){1'b0}}, 1'b1};
          if (sweep_ptr == {IDX_W{1'b1}}) begin
            state <= ST_RUN;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= {GHR_W{1'b0}};
    end else if (rdy) begin
      ghr <= ghr_next;
    end
  end

`ifdef GSHARE_BP_STATS_EN
  // Saturating statistics counters for accepted lookups and mispredicts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_stat_lookups     <= 32'd0;
      out_stat_mispredicts <= 32'd0;
    end else begin
      if (fetch_fire && (out_stat_lookups != 32'hFFFF_FFFF)) begin
        out_stat_lookups <= out_stat_lookups + 32'd1;
      end
      if (misp_fire && (out_stat_mispredicts != 32'hFFFF_FFFF)) begin
        out_stat_mispredicts <= out_stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gshare_bp.sv
// -----------------------------------------------------------------------------
// tb_gshare_bp -- scoreboard bench for gshare_bp (defaults IDX_W=8, CTR_W=2,
// GHR_W=8). Stimulus pushes hand-computed expectations into a queue; the
// monitor drains and compares them on the falling clock edge.
// Statistics checks are compiled only with GSHARE_BP_STATS_EN.
// -----------------------------------------------------------------------------
module tb_gshare_bp;

    localparam int IDX_W = 8;
    localparam int CTR_W = 2;
    localparam int GHR_W = 8;

    localparam int S_JUMP = 0;
    localparam int S_GHR  = 1;
    localparam int S_BUSY = 2;
    localparam int S_CTR  = 3;
    localparam int S_LOOK = 4;
    localparam int S_MISP = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             in_fetcher_ce;
    logic [31:0]      in_fetcher_pc;
    logic             out_fetcher_jump_ce;
    logic [GHR_W-1:0] out_fetcher_ghr;
    logic             in_rob_bp_ce;
    logic [31:0]      in_rob_pc;
    logic [GHR_W-1:0] in_rob_ghr;
    logic             in_rob_jump_ce;
    logic             in_rob_mispredict;
    logic             out_busy;
`ifdef GSHARE_BP_STATS_EN
    logic [31:0]      out_stat_lookups;
    logic [31:0]      out_stat_mispredicts;
`endif

    // Free-running clock.
    always #5 clk = ~clk;

    gshare_bp #(.IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_fetcher_ce       (in_fetcher_ce),
        .in_fetcher_pc       (in_fetcher_pc),
        .out_fetcher_jump_ce (out_fetcher_jump_ce),
        .out_fetcher_ghr     (out_fetcher_ghr),
        .in_rob_bp_ce        (in_rob_bp_ce),
        .in_rob_pc           (in_rob_pc),
        .in_rob_ghr          (in_rob_ghr),
        .in_rob_jump_ce      (in_rob_jump_ce),
        .in_rob_mispredict   (in_rob_mispredict),
        .out_busy            (out_busy)
`ifdef GSHARE_BP_STATS_EN
        ,
        .out_stat_lookups     (out_stat_lookups),
        .out_stat_mispredicts (out_stat_mispredicts)
`endif
    );

    typedef struct {
        string       name;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void expect_val(input string name, input int sel,
                                       input int idx, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endfunction

    task automatic check_now(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (direct): got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation against the DUT outputs.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_JUMP: act = {31'd0, out_fetcher_jump_ce};
                S_GHR:  act = {{(32-GHR_W){1'b0}}, out_fetcher_ghr};
                S_BUSY: act = {31'd0, out_busy};
                S_CTR:  act = {{(32-CTR_W){1'b0}}, dut.u_pht.mem[e.idx]};
`ifdef GSHARE_BP_STATS_EN
                S_LOOK: act = out_stat_lookups;
                S_MISP: act = out_stat_mispredicts;
`endif
                default: act = 32'hDEAD_BEEF;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fce, input logic [31:0] fpc,
                         input logic rce, input logic [31:0] rpc,
                         input logic [GHR_W-1:0] rghr, input logic rj,
                         input logic rm);
        in_fetcher_ce     = fce;
        in_fetcher_pc     = fpc;
        in_rob_bp_ce      = rce;
        in_rob_pc         = rpc;
        in_rob_ghr        = rghr;
        in_rob_jump_ce    = rj;
        in_rob_mispredict = rm;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset pulse followed by the full 256-entry init sweep.
    task automatic reset_and_sweep(input bit check);
        rst = 1'b0;
        tick();
        tick();
        if (check) check_now("resweep_rst_busy", {31'd0, out_busy}, 32'd1);
        rst = 1'b1;
        for (int c = 1; c <= 256; c++) begin
            tick();
            if (check && c == 255) expect_val("busy_before_last", S_BUSY, 0, 32'd1);
            if (check && c == 256) begin
                expect_val("busy_fell_256", S_BUSY, 0, 32'd0);
                check_now("resweep_busy_fell_256", {31'd0, out_busy}, 32'd0);
            end
        end
        idle();
    endtask

    int exp33[4] = '{2, 3, 3, 3};

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        repeat (3) tick();
        expect_val("rst_busy", S_BUSY, 0, 32'd1);
        expect_val("rst_jump", S_JUMP, 0, 32'd0);
        expect_val("rst_ghr",  S_GHR,  0, 32'h00);
        check_now("rst_busy_now", {31'd0, out_busy}, 32'd1);
        check_now("rst_jump_now", {31'd0, out_fetcher_jump_ce}, 32'd0);
        check_now("rst_ghr_now",  {{(32-GHR_W){1'b0}}, out_fetcher_ghr}, 32'h00);
        tick();
        rst = 1'b1;

        // Partial sweep, then reset again: the sweep must restart from index 0.
        repeat (50) tick();
        rst = 1'b0;
        tick();
        expect_val("rst_mid_init_busy", S_BUSY, 0, 32'd1);
        rst = 1'b1;

        // Queries while busy are ignored and predict not-taken.
        drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        for (int c = 1; c <= 256; c++) begin
            tick();
            if (c == 100) begin
                expect_val("busy_q100_jump", S_JUMP, 0, 32'd0);
                expect_val("busy_q100_busy", S_BUSY, 0, 32'd1);
                expect_val("busy_q100_ghr",  S_GHR,  0, 32'h00);
                check_now("busy_q100_busy_now", {31'd0, out_busy}, 32'd1);
            end
            if (c == 255) expect_val("busy_at_255", S_BUSY, 0, 32'd1);
            if (c == 256) begin
                expect_val("busy_at_256", S_BUSY, 0, 32'd0);
                check_now("busy_fell_256_now", {31'd0, out_busy}, 32'd0);
            end
        end
        idle();
        for (int i = 0; i < 256; i++) expect_val($sformatf("init_ctr_%0d", i), S_CTR, i, 32'd1);
        expect_val("ghr_after_init", S_GHR, 0, 32'h00);
        tick();

        // Four taken updates at pc 0x40 / ghr 0 -> index 0x10.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
            tick();
            idle();
            expect_val($sformatf("sat_up_%0d", k), S_CTR, 'h10, 32'(exp33[k]));
        end
        drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("pred_after_train", S_JUMP, 0, 32'd1);
        tick();

        // History build-up: predictions 1, 0, 1 -> GHR 0x05.
        drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("hist_q1_jump", S_JUMP, 0, 32'd1);
        tick();
        expect_val("hist_ghr_01", S_GHR, 0, 32'h01);
        drive(1'b1, 32'h80, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("hist_q2_jump", S_JUMP, 0, 32'd0);
        tick();
        expect_val("hist_ghr_02", S_GHR, 0, 32'h02);
        drive(1'b1, 32'h48, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("hist_q3_jump", S_JUMP, 0, 32'd1);
        tick();
        idle();
        expect_val("hist_ghr_05", S_GHR, 0, 32'h05);

        // Same-cycle query and update to index 0x25: query sees the old value.
        drive(1'b1, 32'h80, 1'b1, 32'h80, 8'h05, 1'b1, 1'b0);
        expect_val("rbw_jump_old", S_JUMP, 0, 32'd0);
        tick();
        idle();
        expect_val("rbw_ctr_new", S_CTR, 'h25, 32'd2);
        expect_val("rbw_ghr_0a",  S_GHR, 0, 32'h0A);

        // Mispredict recovery beats the speculative shift in the same cycle.
        drive(1'b1, 32'h40, 1'b1, 32'h0, 8'h12, 1'b1, 1'b1);
        expect_val("misp_fetch_jump", S_JUMP, 0, 32'd0);
        tick();
        idle();
        expect_val("misp_ghr_25",   S_GHR, 0, 32'h25);
        expect_val("misp_ctr_12",   S_CTR, 'h12, 32'd2);
        expect_val("misp_ctr_1a",   S_CTR, 'h1A, 32'd1);

        // Aliasing: pc 0x404 with GHR 0x01 and pc 0x400 with GHR 0x00 hit index 0.
        drive(1'b0, 32'h0, 1'b1, 32'h3FC, 8'h00, 1'b1, 1'b1);
        tick();
        idle();
        expect_val("alias_ghr_01", S_GHR, 0, 32'h01);
        expect_val("alias_ctr_ff", S_CTR, 'hFF, 32'd2);
        drive(1'b0, 32'h404, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("alias_q404_jump", S_JUMP, 0, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h404, 8'h01, 1'b1, 1'b0);
        tick();
        idle();
        expect_val("alias_ctr_00", S_CTR, 0, 32'd2);
        drive(1'b0, 32'h0, 1'b1, 32'h3FC, 8'h00, 1'b0, 1'b1);
        tick();
        idle();
        expect_val("alias_ghr_00", S_GHR, 0, 32'h00);
        expect_val("alias_ctr_ff_dn", S_CTR, 'hFF, 32'd1);
        drive(1'b0, 32'h400, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        expect_val("alias_q400_jump", S_JUMP, 0, 32'd1);
        tick();

        // Decrement saturates at zero (pc 0xCC / ghr 0 -> index 0x33).
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 32'hCC, 8'h00, 1'b0, 1'b0);
            tick();
            idle();
            expect_val($sformatf("sat_dn_%0d", k), S_CTR, 'h33, 32'd0);
        end

        // rdy low: neither the history nor the table may move.
        rdy = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 32'h40, 8'h12, 1'b0, 1'b1);
        repeat (3) tick();
        expect_val("hold_ghr", S_GHR, 0, 32'h00);
        expect_val("hold_ctr", S_CTR, 'h10, 32'd3);
        rdy = 1'b1;
        idle();
        tick();

`ifdef GSHARE_BP_STATS_EN
        reset_and_sweep(1'b1);
        expect_val("stat_look_zero", S_LOOK, 0, 32'd0);
        expect_val("stat_misp_zero", S_MISP, 0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(k * 4), 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 32'(k * 4), 8'h00, 1'b1, 1'b1);
            tick();
        end
        idle();
        expect_val("stat_look_10", S_LOOK, 0, 32'd10);
        expect_val("stat_misp_3",  S_MISP, 0, 32'd3);
        rdy = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b1);
        repeat (5) tick();
        expect_val("stat_hold_look", S_LOOK, 0, 32'd10);
        expect_val("stat_hold_misp", S_MISP, 0, 32'd3);
        rdy = 1'b1;
        idle();
        tick();
`else
        reset_and_sweep(1'b1);
        expect_val("resweep_ctr_10", S_CTR, 'h10, 32'd1);
        expect_val("resweep_ghr", S_GHR, 0, 32'h00);
`endif

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gshare_bp.md
GSHARE_BP -- requirements
Module: gshare_bp

Interface
REQ-001 SHALL have parameter IDX_W, default 8: pattern-table index width (table depth 2^IDX_W).
REQ-002 SHALL have parameter CTR_W, default 2: saturating-counter width (2..4).
REQ-003 SHALL have parameter GHR_W, default 8: global-history width (1..IDX_W).
REQ-004 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port rdy  in  1: global enable; all state holds while low.
REQ-007 SHALL have port in_fetcher_ce  in  1: fetcher has a conditional branch this cycle.
REQ-008 SHALL have port in_fetcher_pc  in  32: fetch branch PC.
REQ-009 SHALL have port out_fetcher_jump_ce  out  1: prediction, 1 = taken.
REQ-010 SHALL have port out_fetcher_ghr  out  GHR_W: history snapshot used for this prediction.
REQ-011 SHALL have port in_rob_bp_ce  in  1: committed branch update valid.
REQ-012 SHALL have port in_rob_pc  in  32: committed branch PC.
REQ-013 SHALL have port in_rob_ghr  in  GHR_W: snapshot returned from the fetch.
REQ-014 SHALL have port in_rob_jump_ce  in  1: actual outcome, 1 = taken.
REQ-015 SHALL have port in_rob_mispredict  in  1: committed branch was mispredicted.
REQ-016 SHALL have port out_busy  out  1: table initialisation in progress.

Function
REQ-017 SHALL compute index = in_fetcher_pc[IDX_W+1:2] XOR zero-extended GHR; the update index SHALL use in_rob_pc and in_rob_ghr the same way.
REQ-018 SHALL drive out_fetcher_jump_ce combinationally as the MSB of the indexed counter, and as 0 while out_busy is high.
REQ-019 SHALL drive out_fetcher_ghr combinationally with the current GHR.
REQ-020 SHALL, on in_fetcher_ce with rdy high and out_busy low, shift GHR left by one and insert the prediction, one cycle later.
REQ-021 SHALL, on in_rob_bp_ce, increment the counter (saturating at all-ones) if taken, and otherwise decrement it (saturating at 0).
REQ-022 SHALL, on in_rob_bp_ce with in_rob_mispredict, load GHR with {in_rob_ghr[GHR_W-2:0], in_rob_jump_ce}; this SHALL override any speculative shift in the same cycle.
REQ-023 SHALL return the pre-update counter value on a same-cycle query and update to the same index (read-before-write).
REQ-024 SHALL implement a two-state FSM: INIT writes 2^(CTR_W-1)-1 to one entry per cycle from index 0 up to the last index, then moves to RUN; out_busy = (state == INIT).
REQ-025 SHALL ignore rob updates and fetch GHR shifts while in INIT.

Reset
REQ-026 SHALL, on rst low, immediately set GHR = 0, the sweep pointer = 0, state = INIT, and statistics = 0; out_busy SHALL read 1.
REQ-027 SHALL restart the sweep from index 0 if reset is asserted during INIT.

Configuration
REQ-028 SHALL, with GSHARE_BP_STATS_EN defined, add 32-bit outputs out_stat_lookups and out_stat_mispredicts, counting accepted fetch queries and rob mispredicts, saturating at 0xFFFFFFFF.
REQ-029 SHALL, without GSHARE_BP_STATS_EN, have neither those ports nor those registers.

Structure
REQ-030 SHALL take the default widths, the counter-init constant and the FSM state encodings from the shared package bp_pkg.
REQ-031 SHALL contain a single sub-module bp_pht: the counter array with one asynchronous read port and one write port, shared between the init sweep and rob updates.

Verification
REQ-032 SHALL test: reset, then query at cycle 100 -> jump 0 and busy 1; busy falls after 256 cycles; every entry then reads 2'b01.
REQ-033 SHALL test: four taken updates at pc 0x40 with ghr 0x00 -> counter 10, 11, 11, 11; a subsequent query predicts 1.
REQ-034 SHALL test: GHR 0x00 with three fetch queries predicting 1, 0, 1 -> GHR 0x05 and out_fetcher_ghr 0x05.
REQ-035 SHALL test: a mispredict with in_rob_ghr 0x12, taken, in the same cycle as a fetch query -> GHR 0x25 and the speculative shift dropped.
REQ-036 SHALL test: pc 0x404 with GHR 0x01 -> index 0x00, and an update there is seen by pc 0x400 with GHR 0x00.
REQ-037 SHALL test, with GSHARE_BP_STATS_EN: 10 queries and 3 mispredicts -> lookups 10, mispredicts 3; rdy low for 5 cycles leaves both unchanged.
